// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// FSM state encoding and ALU function codes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        STAT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [3:0] FN_NOP  = 4'h0;
    localparam logic [3:0] FN_ADD  = 4'h1;
    localparam logic [3:0] FN_SUB  = 4'h2;
    localparam logic [3:0] FN_AND  = 4'h3;
    localparam logic [3:0] FN_OR   = 4'h4;
    localparam logic [3:0] FN_XOR  = 4'h5;
    localparam logic [3:0] FN_SLL  = 4'h6;
    localparam logic [3:0] FN_SRL  = 4'h7;
    localparam logic [3:0] FN_SRA  = 4'h8;
    localparam logic [3:0] FN_SLT  = 4'h9;
    localparam logic [3:0] FN_SLTU = 4'hA;
    localparam logic [3:0] FN_PASS = 4'hB;
    localparam logic [3:0] FN_NOT  = 4'hC;

    // Any code above this one is undefined and flagged on the response
    localparam logic [3:0] FUNC_MAX = FN_NOT;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester
// that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |valid;
        grant_id    = 1'b0;
        if (valid == 2'b11) begin
            grant_id = ~last;
        end else begin
            grant_id = valid[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; each grant runs
// IDLE -> EXEC -> STAT -> RESP and returns result plus status.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*FUNC_W-1:0] req_func,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [1:0]          req_imm,
    input  logic [2*DATA_W-1:0] req_imm_val,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [DATA_W-1:0]   alu_imm_val,
    output logic                alu_imm,
    output logic [FUNC_W-1:0]   alu_func,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic [7:0]          alu_status,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic [7:0]          resp_status,
    output logic                resp_id,
    output logic                resp_err
);

    state_e state_q, state_d;
    logic   last_q, last_d;

    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] alu_imm_val_q, alu_imm_val_d;
    logic              alu_imm_q, alu_imm_d;
    logic [FUNC_W-1:0] alu_func_q, alu_func_d;

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [7:0]        resp_status_q, resp_status_d;
    logic              resp_id_q, resp_id_d;
    logic              resp_err_q, resp_err_d;

    logic gnt_valid;
    logic gnt_id;
    logic grant;

    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] sel_imm_val;
    logic              sel_imm;
    logic [FUNC_W-1:0] sel_func;

    rr_arb2 u_rr_arb2 (
        .valid       (req_valid),
        .last        (last_q),
        .grant_valid (gnt_valid),
        .grant_id    (gnt_id)
    );

    // Grant is only offered in IDLE and never while reset is held
    assign grant = (state_q == IDLE) && gnt_valid && !rst;

    always_comb begin
        sel_a       = gnt_id ? req_a[2*DATA_W-1:DATA_W]
                             : req_a[DATA_W-1:0];
        sel_b       = gnt_id ? req_b[2*DATA_W-1:DATA_W]
                             : req_b[DATA_W-1:0];
        sel_imm_val = gnt_id ? req_imm_val[2*DATA_W-1:DATA_W]
                             : req_imm_val[DATA_W-1:0];
        sel_func    = gnt_id ? req_func[2*FUNC_W-1:FUNC_W]
                             : req_func[FUNC_W-1:0];
        sel_imm     = gnt_id ? req_imm[1] : req_imm[0];
    end

    always_comb begin
        req_ready = 2'b00;
        if (grant) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_imm_val_d = alu_imm_val_q;
        alu_imm_d     = alu_imm_q;
        alu_func_d    = alu_func_q;
        resp_valid_d  = resp_valid_q;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        resp_id_d     = resp_id_q;
        resp_err_d    = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d       = EXEC;
                    last_d        = gnt_id;
                    alu_a_d       = sel_a;
                    alu_b_d       = sel_b;
                    alu_imm_val_d = sel_imm_val;
                    alu_imm_d     = sel_imm;
                    alu_func_d    = sel_func;
                    resp_id_d     = gnt_id;
                    resp_err_d    = sel_func > FUNC_W'(FUNC_MAX);
                end
            end
            EXEC: begin
                state_d     = STAT;
                resp_data_d = alu_out;
            end
            STAT: begin
                // ALU status trails its operands by one clock
                state_d       = RESP;
                resp_status_d = alu_status;
                resp_valid_d  = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_imm_val_q <= '0;
            alu_imm_q     <= 1'b0;
            alu_func_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_status_q <= '0;
            resp_id_q     <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_imm_val_q <= alu_imm_val_d;
            alu_imm_q     <= alu_imm_d;
            alu_func_q    <= alu_func_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
            resp_id_q     <= resp_id_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_imm_val = alu_imm_val_q;
    assign alu_imm     = alu_imm_q;
    assign alu_func    = alu_func_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_status = resp_status_q;
    assign resp_id     = resp_id_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU
// (status: bit0 zero, bit1 negative, bit3 carry/no-borrow).
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_func;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_imm;
    logic [63:0] req_imm_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_imm_val;
    logic        alu_imm;
    logic [3:0]  alu_func;
    logic [31:0] alu_out;
    logic [7:0]  alu_status;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [7:0]  resp_status;
    logic        resp_id;
    logic        resp_err;

    int n_vec;
    int n_bad;

    alu_arbiter #(.DATA_W(32), .FUNC_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_func    (req_func),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_imm     (req_imm),
        .req_imm_val (req_imm_val),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_imm_val (alu_imm_val),
        .alu_imm     (alu_imm),
        .alu_func    (alu_func),
        .alu_out     (alu_out),
        .alu_status  (alu_status),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_status (resp_status),
        .resp_id     (resp_id),
        .resp_err    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] sum;
    logic        carry;

    always_comb begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b};
        carry   = 1'b0;
        alu_out = alu_a;
        case (alu_func)
            4'h1: begin alu_out = sum[31:0]; carry = sum[32]; end
            4'h2: begin alu_out = alu_a - alu_b; carry = (alu_a >= alu_b); end
            4'h3: alu_out = alu_a & alu_b;
            4'h4: alu_out = alu_a | alu_b;
            default: alu_out = alu_a;
        endcase
    end

    always @(posedge clk) begin
        alu_status <= {4'b0, carry, 1'b0, alu_out[31], alu_out == 32'd0};
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        req_valid   = 2'b01;
        req_func    = '0;
        req_a       = '0;
        req_b       = '0;
        req_imm     = '0;
        req_imm_val = '0;
        resp_ready  = 1'b1;
        #2;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_rstatus", resp_status, 0);
        chk("rst_rid", resp_id, 0);
        chk("rst_rerr", resp_err, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_func", alu_func, 0);
        step();
        chk("rst_hold_ready", req_ready, 2'b00);

        // single request on requester 0: 5 + 7
        rst          = 1'b0;
        req_func[3:0] = 4'h1;
        req_a[31:0]  = 32'd5;
        req_b[31:0]  = 32'd7;
        #1;
        chk("t1_grant", req_ready, 2'b01);
        step();
        req_valid     = 2'b10;
        req_func[7:4] = 4'h2;
        req_a[63:32]  = 32'd9;
        req_b[63:32]  = 32'd9;
        #1;
        chk("t1_busy_ready", req_ready, 2'b00);
        chk("t1_alu_a", alu_a, 5);
        chk("t1_alu_b", alu_b, 7);
        chk("t1_alu_func", alu_func, 1);
        step();
        chk("t1_stat_rvalid", resp_valid, 0);
        step();
        chk("t1_rvalid", resp_valid, 1);
        chk("t1_rdata", resp_data, 12);
        chk("t1_rid", resp_id, 0);
        chk("t1_rerr", resp_err, 0);

        // requester 1 was held valid through the busy period
        step();
        chk("t2_idle_rvalid", resp_valid, 0);
        chk("t2_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("t2_rvalid", resp_valid, 1);
        chk("t2_rdata", resp_data, 0);
        chk("t2_zero", resp_status[0], 1);
        chk("t2_neg", resp_status[1], 0);
        chk("t2_carry", resp_status[3], 1);
        chk("t2_rid", resp_id, 1);
        step();

        // both requesters valid from reset: 0,1,0,1
        rst           = 1'b1;
        req_valid     = 2'b11;
        req_func      = 8'h31;
        req_a         = {32'h0000_00F0, 32'd1};
        req_b         = {32'h0000_003C, 32'd2};
        #1;
        chk("t3_rst_rvalid", resp_valid, 0);
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            step();
            step();
            step();
            chk("t3_rvalid", resp_valid, 1);
            chk("t3_rid", resp_id, k % 2);
            chk("t3_rdata", resp_data, (k % 2 == 1) ? 32'h30 : 32'd3);
            step();
        end

        // consumer stalls for 5 cycles in RESP
        resp_ready = 1'b0;
        #1;
        chk("t4_grant", req_ready, 2'b01);
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_rvalid", resp_valid, 1);
            chk("t4_stall_rdata", resp_data, 3);
            chk("t4_stall_ready", req_ready, 2'b00);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("t4_rise_rvalid", resp_valid, 1);
        step();
        chk("t4_next_grant", req_ready, 2'b10);
        step();
        req_valid     = 2'b01;
        req_func[3:0] = 4'hE;
        req_a[31:0]   = 32'd3;
        req_b[31:0]   = 32'd4;
        step();
        step();
        chk("t4_rid", resp_id, 1);
        chk("t4_rdata", resp_data, 32'h30);

        // undefined function code
        step();
        chk("t5_grant", req_ready, 2'b01);
        step();
        req_valid     = 2'b10;
        req_func[7:4] = 4'h1;
        req_a[63:32]  = 32'd10;
        req_b[63:32]  = 32'd20;
        step();
        step();
        chk("t5_rerr", resp_err, 1);
        chk("t5_rdata", resp_data, 3);
        chk("t5_rid", resp_id, 0);

        // reset during STAT aborts, then a fresh request completes
        step();
        chk("t6_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
        rst = 1'b1;
        #1;
        chk("t6_abort_rvalid", resp_valid, 0);
        chk("t6_abort_alu_a", alu_a, 0);
        step();
        chk("t6_hold_rvalid", resp_valid, 0);
        rst           = 1'b0;
        req_valid     = 2'b01;
        req_func[3:0] = 4'h4;
        req_a[31:0]   = 32'h0000_00F0;
        req_b[31:0]   = 32'h0000_000F;
        #1;
        chk("t6_grant2", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        chk("t6_exec_rvalid", resp_valid, 0);
        step();
        step();
        chk("t6_rvalid", resp_valid, 1);
        chk("t6_rdata", resp_data, 32'hFF);
        chk("t6_rid", resp_id, 0);
        chk("t6_rerr", resp_err, 0);
        step();
        chk("t6_done_rvalid", resp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the operand and result width.
REQ-002 The block SHALL have parameter FUNC_W, default 4, meaning the ALU function-code width.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 The block SHALL have port req_ready  output  2  per-requester request accepted.
REQ-007 The block SHALL have port req_func  input  2*FUNC_W  per-requester function code; requester i occupies slice i.
REQ-008 The block SHALL have port req_a  input  2*DATA_W  per-requester operand a.
REQ-009 The block SHALL have port req_b  input  2*DATA_W  per-requester operand b.
REQ-010 The block SHALL have port req_imm  input  2  per-requester immediate select.
REQ-011 The block SHALL have port req_imm_val  input  2*DATA_W  per-requester immediate value.
REQ-012 The block SHALL have ports alu_a, alu_b, alu_imm_val (output, DATA_W), alu_imm (output, 1) and alu_func (output, FUNC_W), all driving the shared ALU.
REQ-013 The block SHALL have port alu_out  input  DATA_W  combinational ALU result.
REQ-014 The block SHALL have port alu_status  input  8  ALU status register, valid one clock after operands are applied.
REQ-015 The block SHALL have port resp_valid  output  1  response valid.
REQ-016 The block SHALL have port resp_ready  input  1  response consumer ready.
REQ-017 The block SHALL have ports resp_data (output, DATA_W), resp_status (output, 8), resp_id (output, 1) and resp_err (output, 1).

Function
REQ-018 The FSM SHALL have four states, IDLE, EXEC, STAT and RESP, with transitions IDLE->EXEC on any req_valid, EXEC->STAT, STAT->RESP, RESP->IDLE when resp_valid && resp_ready, and no other transitions.
REQ-019 In IDLE, arbitration SHALL be round-robin: if both requesters are valid, the one not equal to last_grant wins; a single valid requester wins outright.
REQ-020 req_ready[g] SHALL pulse high for exactly one cycle, in the IDLE cycle that grants requester g; the operands of g SHALL be captured into internal registers on that edge.
REQ-021 last_grant SHALL update to g on every grant.
REQ-022 In EXEC and STAT, the alu_* outputs SHALL drive the captured operands; in all other states they SHALL be held at their last value.
REQ-023 At the end of EXEC, alu_out SHALL be latched into resp_data.
REQ-024 At the end of STAT, alu_status SHALL be latched into resp_status; this accounts for the ALU's one-clock status latency.
REQ-025 In RESP, resp_valid SHALL be 1 and resp_data, resp_status, resp_id and resp_err SHALL be stable until the handshake completes.
REQ-026 Grant-to-resp_valid latency SHALL be 3 cycles, and back-to-back throughput SHALL be one operation per 4 cycles while resp_ready is held at 1.
REQ-027 resp_err SHALL be 1 when the captured func exceeds 4'hC (undefined code); resp_data SHALL still carry alu_out unmodified.
REQ-028 Requests arriving while not in IDLE SHALL be ignored (req_ready stays 0), and requesters SHALL hold req_valid until granted.
REQ-029 Deasserting req_valid in the same cycle as the grant SHALL NOT cancel the grant.
REQ-030 Arithmetic width SHALL be DATA_W throughout; the arbiter SHALL perform no arithmetic on data.

Reset
REQ-031 On rst=1, the block SHALL asynchronously set state=IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_status=0, resp_id=0, resp_err=0, alu_* outputs=0 and last_grant=1, so that requester 0 wins the first tie.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no response; after release, the first grant SHALL occur no earlier than the first clock edge.

Structure
REQ-033 The FSM state encoding, the ALU function codes (NOP=0 through NOT=4'hC) and the FUNC_MAX constant SHALL reside in the shared package alu_pkg.
REQ-034 The round-robin selector SHALL be the single sub-module rr_arb2 (inputs: valid[1:0], last; outputs: grant_valid, grant_id).

Verification
REQ-035 A single request with req0 func=1, a=5, b=7 SHALL produce resp_valid 3 cycles after the grant with resp_data=12, resp_id=0 and resp_err=0.
REQ-036 A request with req1 func=2, a=9, b=9 SHALL produce resp_data=0 with resp_status[0]=1, resp_status[1]=0 and resp_status[3]=1.
REQ-037 With both requesters valid continuously from reset, grants SHALL follow the order 0,1,0,1, with resp_id matching that order.
REQ-038 Holding resp_ready=0 for 5 cycles while in RESP SHALL keep resp_valid and resp_data stable, keep both req_ready bits at 0, and issue the next grant 1 cycle after resp_ready rises.
REQ-039 A request with func=4'hE SHALL produce resp_err=1.
REQ-040 Asserting rst during STAT SHALL bring resp_valid to 0 immediately with no response emitted, and a subsequent request SHALL complete normally.
